// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns engine: one NB-column state per transaction,
// LANES columns transformed per cycle, result held until the consumer takes it.
module mix_columns_engine #(
    parameter int NB    = 4,
    parameter int LANES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            inv_en,
    input  logic [32*NB-1:0] state_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*NB-1:0] state_out,
    output logic            busy
);

    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     col_cnt;
    logic              mode;
    logic [32*NB-1:0]  work;
    logic [32*NB-1:0]  work_nxt;
    logic [31:0]       cols     [NB];
    logic [31:0]       lane_out [LANES];
    logic              accept;
    logic              last_grp;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // One output byte from the byte in its own row (p) and the three that follow it.
    function automatic logic [7:0] mix_byte(input logic [7:0] p, input logic [7:0] q,
                                            input logic [7:0] s, input logic [7:0] t,
                                            input logic inv);
        logic [7:0] p2, p4, p8, q2, q4, q8, s2, s4, s8, t2, t4, t8;
        p2 = xtime(p);  p4 = xtime(p2);  p8 = xtime(p4);
        q2 = xtime(q);  q4 = xtime(q2);  q8 = xtime(q4);
        s2 = xtime(s);  s4 = xtime(s2);  s8 = xtime(s4);
        t2 = xtime(t);  t4 = xtime(t2);  t8 = xtime(t4);
        if (inv)
            return (p8 ^ p4 ^ p2) ^ (q8 ^ q2 ^ q) ^ (s8 ^ s4 ^ s) ^ (t8 ^ t);
        else
            return p2 ^ (q2 ^ q) ^ s ^ t;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {mix_byte(a0, a1, a2, a3, inv), mix_byte(a1, a2, a3, a0, inv),
                mix_byte(a2, a3, a0, a1, inv), mix_byte(a3, a0, a1, a2, inv)};
    endfunction

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign last_grp = (int'(col_cnt) + LANES) == NB;

    // Only LANES transform units; each lane picks its column from the current group.
    for (genvar c = 0; c < NB; c++) begin : g_col
        assign cols[c] = work[32*(NB-c)-1 -: 32];
        assign work_nxt[32*(NB-c)-1 -: 32] =
            (col_cnt == CW'(c - (c % LANES))) ? lane_out[c % LANES] : cols[c];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_out[l] = mix_col(cols[col_cnt + CW'(l)], mode);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            work <= state_in;
            mode <= inv_en;
        end else if (state == RUN) begin
            work <= work_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col_cnt   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        col_cnt <= '0;
                    end
                end
                RUN: begin
                    if (last_grp) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state_out <= work_nxt;
                        col_cnt   <= '0;
                    end else begin
                        col_cnt <= col_cnt + CW'(LANES);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            col_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench for mix_columns_engine with LANES = 1, 2 and 4 instances side by side.
module tb_mix_columns_engine;

    localparam logic [127:0] T1_IN    = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] T1_OUT   = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] COLS_IN  = 128'hdb135345_f20a225c_c6c6c6c6_2d26314c;
    localparam logic [127:0] COLS_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         inv_en    [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] state_in  [3];
    logic [127:0] state_out [3];

    logic         or_rand  [3];
    logic         or_force [3];
    logic         prev_ov  [3];
    int           acc_cyc  [3];
    int           lat_exp  [3] = '{4, 2, 1};
    logic [127:0] exp_q    [3][$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    mix_columns_engine #(.NB(4), .LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .inv_en(inv_en[0]), .state_in(state_in[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .state_out(state_out[0]), .busy(busy[0]));

    mix_columns_engine #(.NB(4), .LANES(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .inv_en(inv_en[1]), .state_in(state_in[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .state_out(state_out[1]), .busy(busy[1]));

    mix_columns_engine #(.NB(4), .LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .inv_en(inv_en[2]), .state_in(state_in[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .state_out(state_out[2]), .busy(busy[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] r;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) a[rr] = s[127-32*c-8*rr -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b = b ^ gmul(m[j], a[(rr+j)%4]);
                r[127-32*c-8*rr -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input int k, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[lanes_inst %0d] actual=%0h required=%0h", name, k, act, req);
        end
    endtask

    task automatic fail(input string name, input int k);
        checks++;
        errors++;
        $display("FAIL %s[lanes_inst %0d] actual=timeout/unexpected required=event", name, k);
    endtask

    // Single driver of out_ready: random backpressure or a forced level.
    initial begin
        for (int k = 0; k < 3; k++) out_ready[k] = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 3; k++)
                out_ready[k] = or_rand[k] ? ($urandom_range(0, 3) != 0) : or_force[k];
        end
    end

    // Monitor: pops the scoreboard on every completed output handshake.
    initial begin
        for (int k = 0; k < 3; k++) prev_ov[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    prev_ov[k] = 1'b0;
                end else begin
                    if (out_valid[k] && !prev_ov[k])
                        chk("latency", k, 128'(cyc - acc_cyc[k]), 128'(lat_exp[k]));
                    if (out_valid[k] && out_ready[k]) begin
                        if (exp_q[k].size() == 0) fail("unexpected_output", k);
                        else chk("state_out", k, state_out[k], exp_q[k].pop_front());
                    end
                    prev_ov[k] = out_valid[k];
                end
            end
        end
    end

    // Entered and left just after a rising edge.
    task automatic send(input int k, input logic [127:0] d, input logic inv,
                        input logic [127:0] req, input int gap);
        logic ok;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b1;
        state_in[k] = d;
        inv_en[k]   = inv;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready[k]) begin
                ok = 1'b1;
                exp_q[k].push_back(req);
                acc_cyc[k] = cyc + 1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid[k] = 1'b0;
        state_in[k] = ~d;
        inv_en[k]   = ~inv;
        if (!ok) fail("accept_timeout", k);
    endtask

    task automatic drain(input int bound);
        for (int n = 0; n < bound; n++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0) break;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) chk("drain_empty", k, 128'(exp_q[k].size()), 128'd0);
    endtask

    task automatic rand_run(input int k, input int n);
        logic [127:0] d;
        logic         inv;
        for (int i = 0; i < n; i++) begin
            d   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            send(k, d, inv, model(d, inv), $urandom_range(0, 2));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog[lanes_inst 0] actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0;
            inv_en[k]   = 1'b0;
            state_in[k] = '0;
            or_rand[k]  = 1'b0;
            or_force[k] = 1'b1;
            acc_cyc[k]  = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", k, 128'(out_valid[k]), 128'd0);
            chk("rst_busy", k, 128'(busy[k]), 128'd0);
            chk("rst_state_out", k, state_out[k], 128'd0);
            chk("rst_in_ready", k, 128'(in_ready[k]), 128'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Forward known-answer then inverse round trip on every lane count.
        for (int k = 0; k < 3; k++) begin
            send(k, T1_IN, 1'b0, T1_OUT, 0);
            send(k, T1_OUT, 1'b1, T1_IN, 0);
        end
        send(0, COLS_IN, 1'b0, COLS_OUT, 0);
        send(1, COLS_IN, 1'b0, COLS_OUT, 0);
        send(2, COLS_OUT, 1'b1, COLS_IN, 0);
        drain(100);

        // Backpressure: result held, input side stalled with a changing candidate state.
        or_force[0] = 1'b0;
        send(0, COLS_IN, 1'b0, COLS_OUT, 0);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail("bp_out_valid_timeout", 0);
        in_valid[0] = 1'b1;
        inv_en[0]   = 1'b1;
        for (int n = 0; n < 10; n++) begin
            state_in[0] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_out_valid", 0, 128'(out_valid[0]), 128'd1);
            chk("bp_in_ready", 0, 128'(in_ready[0]), 128'd0);
            chk("bp_state_out", 0, state_out[0], COLS_OUT);
        end
        @(posedge clk);
        #1 or_force[0] = 1'b1;
        send(0, T1_IN, 1'b0, T1_OUT, 0);
        @(negedge clk);
        chk("bp_no_bubble_out_valid", 0, 128'(out_valid[0]), 128'd0);
        chk("bp_no_bubble_busy", 0, 128'(busy[0]), 128'd1);
        @(posedge clk);
        #1;
        drain(100);

        // Reset one cycle after an accept: the in-flight state must never appear.
        send(0, T1_IN, 1'b0, T1_OUT, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q[0].delete();
        @(negedge clk);
        chk("midrun_rst_out_valid", 0, 128'(out_valid[0]), 128'd0);
        chk("midrun_rst_busy", 0, 128'(busy[0]), 128'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 0, 128'(out_valid[0]), 128'd0);
            chk("post_rst_in_ready", 0, 128'(in_ready[0]), 128'd1);
        end
        @(posedge clk);
        #1;

        // Random traffic with random input gaps and output backpressure.
        for (int k = 0; k < 3; k++) or_rand[k] = 1'b1;
        fork
            rand_run(0, 1000);
            rand_run(1, 300);
            rand_run(2, 300);
        join
        for (int k = 0; k < 3; k++) begin
            or_rand[k]  = 1'b0;
            or_force[k] = 1'b1;
        end
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
